// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus of the boot loader.
// The master drives the byte stream and receives memory writes; the loader is the slave.
interface imem_loader_if #(
  parameter int ADDR_W = 30
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles big-endian words from a byte stream,
// writes them to consecutive word addresses and releases the CPU once the XOR checksum matches.
module imem_loader #(
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_W     = 30
) (
  input  logic          clock,
  input  logic          reset,
  imem_loader_if.slave  bus,
  output logic          cpu_reset,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_loaded
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam int          IDX_W     = DEPTH_LOG2 + 1;
  localparam logic [32:0] MAX_WORDS = 33'd1 << DEPTH_LOG2;

  state_t            r_state;
  logic [7:0]        r_count_hi;
  logic [15:0]       r_count;
  logic [23:0]       r_word;
  logic [1:0]        r_byte_idx;
  logic [7:0]        r_xor;
  logic [IDX_W-1:0]  r_word_idx;
  logic [15:0]       r_words_loaded;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_done;
  logic              r_error;
  logic              r_cpu_reset;

  logic              w_ready;
  logic              w_xfer;
  logic [15:0]       w_count;
  logic [IDX_W-1:0]  w_next_idx;
  logic              w_last_word;

  assign w_ready     = (r_state == HDR_HI) || (r_state == HDR_LO) ||
                       (r_state == DATA)   || (r_state == CHECK);
  assign w_xfer      = bus.in_valid && w_ready;
  assign w_count     = {r_count_hi, bus.in_data};
  assign w_next_idx  = r_word_idx + IDX_W'(1);
  assign w_last_word = (32'(w_next_idx) == 32'(r_count));

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= HDR_HI;
      r_count_hi     <= '0;
      r_count        <= '0;
      r_word         <= '0;
      r_byte_idx     <= '0;
      r_xor          <= '0;
      r_word_idx     <= '0;
      r_words_loaded <= '0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_cpu_reset    <= 1'b1;
    end else begin
      unique case (r_state)
        HDR_HI: begin
          if (w_xfer) begin
            r_count_hi <= bus.in_data;
            r_state    <= HDR_LO;
          end
        end

        HDR_LO: begin
          if (w_xfer) begin
            r_count <= w_count;
            if (33'(w_count) > MAX_WORDS) begin
              r_state <= ERR;
              r_error <= 1'b1;
            end else if (w_count == 16'd0) begin
              r_state <= CHECK;
            end else begin
              r_state <= DATA;
            end
          end
        end

        DATA: begin
          if (w_xfer) begin
            r_word     <= {r_word[15:0], bus.in_data};
            r_xor      <= r_xor ^ bus.in_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            // The write strobe is registered here so it is high exactly during WRITE.
            if (r_byte_idx == 2'd3) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= ADDR_W'(r_word_idx);
              r_mem_wdata <= {r_word, bus.in_data};
              r_state     <= WRITE;
            end
          end
        end

        WRITE: begin
          r_mem_we       <= 1'b0;
          r_words_loaded <= r_words_loaded + 16'd1;
          r_word_idx     <= w_next_idx;
          r_state        <= w_last_word ? CHECK : DATA;
        end

        CHECK: begin
          if (w_xfer) begin
            if (bus.in_data == r_xor) begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state <= ERR;
              r_error <= 1'b1;
            end
          end
        end

        DONE, ERR: ;

        default: begin
          r_state <= ERR;
          r_error <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign cpu_reset     = r_cpu_reset;
  assign done          = r_done;
  assign error         = r_error;
  assign words_loaded  = r_words_loaded;

endmodule
